sram_bus_adapter: RTL and testbench
===================================

Name: sram_bus_adapter

Overview:
- Upstream of the external-SRAM sequencer. Accepts one 32-bit CPU memory request at a time: byte, half or word, read or write.
- Splits each request into one or two 16-bit sequencer transactions: low half first at addr, then high half at addr+2. Little-endian.
- Assembles the read data and returns one response per request.
- Enforces the sequencer's rules: a one-cycle valid strobe, and address, rw and write data held stable until done.

Parameters:
- TIMEOUT_CYCLES, 64: cycles to wait for sram_done before aborting. Used only with the optional feature.
- TO_W, 7: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  Single clock, rising edge.
- rst_n  in  1  Asynchronous active-low reset. Synchronous deassertion is the integrator's responsibility.
- req_valid  in  1  Request present.
- req_ready  out  1  Adapter can accept a request.
- req_rw  in  1  1 = write.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_addr  in  32  Byte address.
- req_wdata  in  32  Write data. Right-justified for byte and half.
- resp_valid  out  1  One-cycle response strobe.
- resp_rdata  out  32  Read data. Zero-extended for byte and half. 0 for writes.
- resp_err  out  1  Request was misaligned, reserved-size, or timed out.
- sram_valid  out  1  One-cycle transaction strobe to the sequencer.
- sram_rw  out  1  Transaction direction.
- sram_addr  out  32  Transaction byte address. Bit 0 selects the byte lane.
- sram_dtw  out  16  Transaction write data.
- sram_dtr  in  16  Sequencer read data. Valid in the sram_done cycle.
- sram_done  in  1  Sequencer completion pulse.

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, sram_valid 0, sram_rw 0, sram_addr 0, sram_dtw 0. All outputs are registered.
- Accept: a request is captured on req_valid && req_ready. req_ready is 1 only in IDLE.
- States: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
- IDLE, on accept:
  - Error case: size 3, or half with addr[0]=1, or word with addr[1:0]≠0. Go to RESP with err=1. No SRAM traffic.
  - Otherwise go to ISSUE_LO.
- ISSUE_LO:
  - sram_valid=1 for exactly this cycle.
  - Outputs: sram_addr = req_addr (word and half: addr[0]=0), sram_rw = req_rw.
  - sram_dtw: byte → {wdata[7:0], wdata[7:0]}; half and word → wdata[15:0].
  - Go to WAIT_LO.
- WAIT_LO:
  - sram_valid=0. sram_addr, sram_rw and sram_dtw held.
  - On sram_done: capture the low half.
  - Byte read: rdata = {24'b0, addr[0] ? dtr[15:8] : dtr[7:0]}. Half and word: rdata[15:0] = dtr.
  - Next state: word → ISSUE_HI; otherwise → RESP.
- ISSUE_HI:
  - sram_valid=1 for one cycle, sram_addr = addr+2, sram_dtw = wdata[31:16].
  - This is at least one cycle after done, so the sequencer is back in T1 and samples the strobe correctly.
- WAIT_HI: on sram_done, rdata[31:16] = dtr. Go to RESP.
- RESP:
  - resp_valid=1 for one cycle, with resp_rdata and resp_err. Writes return rdata 0.
  - Go to IDLE, where req_ready=1 in the next cycle.
- Latency with the 4-cycle sequencer:
  - Half or byte: accept at cycle 0 → resp_valid at cycle 6.
  - Word: resp_valid at cycle 11.
  - Misaligned: resp_valid at cycle 1.
- sram_done received outside WAIT_LO/WAIT_HI is ignored.
- req_valid while busy is not accepted and has no effect.
- Reset mid-transaction: all state clears immediately; no response is issued. The sequencer has no reset, so the integrator must reset both or hold the adapter in reset for ≥4 cycles.

Optional Feature:
- Macro: SRAM_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entering WAIT_LO/WAIT_HI and increments each wait cycle.
  - Reaching TIMEOUT_CYCLES without sram_done → RESP with err=1 and rdata 0.
  - A late sram_done is ignored.
- Undefined: no counter; the adapter waits indefinitely.

Decomposition:
- Package sram_pkg:
  - Size encoding constants: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum.
  - A misalignment-check function.
- Optional sub-module sram_watchdog: counter with start, tick and expire, instantiated only under SRAM_TIMEOUT_EN.
- Everything else stays in one module.

Test Plan:
- Word write, addr 0x100, wdata 0xDEADBEEF → two strobes: (0x100, dtw 0xBEEF, rw 1) then (0x102, dtw 0xDEAD). resp_valid at cycle 11, err 0.
- Word read, addr 0x200, model returns 0x1234 then 0xABCD → resp_rdata 0xABCD1234, 2 strobes, resp at cycle 11.
- Byte read:
  - addr 0x301, dtr 0x5A77 → rdata 0x0000005A.
  - addr 0x300 → rdata 0x00000077.
  - One strobe each.
- Byte write, addr 0x401, wdata 0x000000C3 → sram_dtw 0xC3C3, sram_addr 0x401.
- Misaligned word at 0x102, then size 3 → each gives resp_err 1 at cycle 1 with zero sram_valid pulses.
- Reset asserted during WAIT_HI → outputs return to reset values asynchronously, no resp_valid. With SRAM_TIMEOUT_EN and sram_done stuck at 0: err 1 after 64 wait cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM bus adapter: size encodings, FSM states
// and the alignment check applied to incoming CPU requests.
package sram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_WAIT_LO,
    ST_ISSUE_HI,
    ST_WAIT_HI,
    ST_RESP
  } state_e;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned for that size.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = a[0];
      SZ_WORD: req_bad = |a;
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sram_watchdog.sv
// Wait-cycle counter for the SRAM adapter. Built only with SRAM_TIMEOUT_EN.
// start clears the count, tick advances it, expire flags the last allowed
// wait cycle so the FSM can abort in that same cycle.
module sram_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tick,
  output logic expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expire = tick && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Next count: clear on start, otherwise count wait cycles until expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (start)                cnt_d = '0;
    else if (tick && !expire) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sram_bus_adapter.sv
// 32-bit CPU request to 16-bit SRAM sequencer adapter. Word requests become
// two transactions (low half at addr, high half at addr+2, little-endian);
// byte and half requests become one. All outputs are registered.
// Optional macro SRAM_TIMEOUT_EN adds a wait timeout (sram_watchdog).
module sram_bus_adapter
  import sram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sram_valid,
  output logic        sram_rw,
  output logic [31:0] sram_addr,
  output logic [15:0] sram_dtw,
  input  logic [15:0] sram_dtr,
  input  logic        sram_done
);

  if (2 ** TO_W <= TIMEOUT_CYCLES) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        rw_q, rw_d, err_q, err_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d, sram_addr_q, sram_addr_d;
  logic        resp_err_q, resp_err_d, sram_valid_q, sram_valid_d;
  logic        sram_rw_q, sram_rw_d;
  logic [15:0] sram_dtw_q, sram_dtw_d;
  logic        timeout;

`ifdef SRAM_TIMEOUT_EN
  logic wd_start, wd_tick;
  assign wd_start = (state_q == ST_ISSUE_LO) || (state_q == ST_ISSUE_HI);
  assign wd_tick  = (state_q == ST_WAIT_LO)  || (state_q == ST_WAIT_HI);

  sram_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (wd_start),
    .tick   (wd_tick),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next state, request capture, read assembly and registered-output values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    size_d       = size_q;
    rw_d         = rw_q;
    err_d        = err_q;
    sram_addr_d  = sram_addr_q;
    sram_rw_d    = sram_rw_q;
    sram_dtw_d   = sram_dtw_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        size_d  = req_size;
        rw_d    = req_rw;
        rdata_d = '0;
        err_d   = req_bad(req_size, req_addr[1:0]);
        state_d = err_d ? ST_RESP : ST_ISSUE_LO;
      end
      ST_ISSUE_LO: state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (sram_done) begin
        if (size_q == SZ_BYTE)
          rdata_d = {24'b0, addr_q[0] ? sram_dtr[15:8] : sram_dtr[7:0]};
        else
          rdata_d = {16'b0, sram_dtr};
        state_d = (size_q == SZ_WORD) ? ST_ISSUE_HI : ST_RESP;
      end else if (timeout) begin
        err_d   = 1'b1;
        state_d = ST_RESP;
      end
      ST_ISSUE_HI: state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (sram_done) begin
        rdata_d[31:16] = sram_dtr;
        state_d        = ST_RESP;
      end else if (timeout) begin
        err_d   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Transaction fields are loaded as the strobe goes out and then held.
    if (state_q == ST_IDLE && state_d == ST_ISSUE_LO) begin
      sram_addr_d = req_addr;
      sram_rw_d   = req_rw;
      sram_dtw_d  = (req_size == SZ_BYTE) ? {2{req_wdata[7:0]}} : req_wdata[15:0];
    end
    if (state_q == ST_WAIT_LO && state_d == ST_ISSUE_HI) begin
      sram_addr_d = addr_q + 32'd2;
      sram_dtw_d  = wdata_q[31:16];
    end

    sram_valid_d = (state_d == ST_ISSUE_LO) || (state_d == ST_ISSUE_HI);
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    if (resp_valid_d) begin
      resp_err_d   = err_d;
      resp_rdata_d = (rw_d || err_d) ? 32'b0 : rdata_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      size_q       <= SZ_BYTE;
      rw_q         <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      sram_valid_q <= 1'b0;
      sram_rw_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_dtw_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      size_q       <= size_d;
      rw_q         <= rw_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      sram_valid_q <= sram_valid_d;
      sram_rw_q    <= sram_rw_d;
      sram_addr_q  <= sram_addr_d;
      sram_dtw_q   <= sram_dtw_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign sram_valid = sram_valid_q;
  assign sram_rw    = sram_rw_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dtw   = sram_dtw_q;

endmodule

// File: tb/tb_sram_bus_adapter.sv
// Directed bench for sram_bus_adapter with a 4-cycle sequencer model.
module tb_sram_bus_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rw;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_valid, sram_rw;
  logic [31:0] sram_addr;
  logic [15:0] sram_dtw;
  logic [15:0] sram_dtr;
  logic        sram_done;

  int n_vec = 0;
  int n_err = 0;

  // Sequencer model state.
  int          dly = 0;
  int          n_strobe = 0;
  int          n_rd = 0;
  bit          seq_mute = 0;
  logic [15:0] rd_vals [2];
  logic [31:0] log_addr [4];
  logic [15:0] log_dtw [4];
  logic        log_rw [4];

  sram_bus_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_valid(sram_valid), .sram_rw(sram_rw), .sram_addr(sram_addr),
    .sram_dtw(sram_dtw), .sram_dtr(sram_dtr), .sram_done(sram_done)
  );

  always #5 clk = ~clk;

  // Sequencer: strobe seen in cycle c gives a done pulse in cycle c+4.
  always @(negedge clk) begin
    sram_done = 1'b0;
    if (!rst_n) dly = 0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        sram_done = 1'b1;
        sram_dtr  = rd_vals[n_rd % 2];
        n_rd++;
      end
    end
    if (sram_valid && rst_n) begin
      if (n_strobe < 4) begin
        log_addr[n_strobe] = sram_addr;
        log_dtw[n_strobe]  = sram_dtw;
        log_rw[n_strobe]   = sram_rw;
      end
      n_strobe++;
      if (!seq_mute) dly = 4;
    end
  end

  // Issue one request; lat is the cycle of resp_valid, accept cycle = 0.
  task automatic do_req(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    n_strobe = 0; n_rd = 0;
    req_valid = 1'b1; req_rw = rw; req_size = sz; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'd0;
    req_addr = '0; req_wdata = '0; sram_dtr = '0; sram_done = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_vec++; if ({resp_valid, resp_err, sram_valid, sram_rw} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {resp_valid, resp_err, sram_valid, sram_rw}); end
    n_vec++; if ({resp_rdata, sram_addr, sram_dtw} !== 80'b0) begin n_err++; $display("FAIL reset_data got %h %h %h want 0", resp_rdata, sram_addr, sram_dtw); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_write();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, lat, rd, er);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL ww_lat got %0d want 11", lat); end
    n_vec++; if ({er, rd} !== 33'b0) begin n_err++; $display("FAIL ww_resp got err %b rdata %h want 0 0", er, rd); end
    n_vec++; if (n_strobe !== 2) begin n_err++; $display("FAIL ww_strobes got %0d want 2", n_strobe); end
    n_vec++; if ({log_addr[0], log_dtw[0], log_rw[0]} !== {32'h100, 16'hBEEF, 1'b1}) begin n_err++; $display("FAIL ww_lo got %h %h %b want 100 beef 1", log_addr[0], log_dtw[0], log_rw[0]); end
    n_vec++; if ({log_addr[1], log_dtw[1], log_rw[1]} !== {32'h102, 16'hDEAD, 1'b1}) begin n_err++; $display("FAIL ww_hi got %h %h %b want 102 dead 1", log_addr[1], log_dtw[1], log_rw[1]); end
  endtask

  task automatic test_word_read();
    int lat; logic [31:0] rd; logic er;
    rd_vals[0] = 16'h1234; rd_vals[1] = 16'hABCD;
    do_req(1'b0, 2'd2, 32'h200, 32'h0, lat, rd, er);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL wr_lat got %0d want 11", lat); end
    n_vec++; if (rd !== 32'hABCD1234 || er !== 1'b0) begin n_err++; $display("FAIL wr_data got %h err %b want abcd1234 0", rd, er); end
    n_vec++; if (n_strobe !== 2 || log_addr[1] !== 32'h202 || log_rw[0] !== 1'b0) begin n_err++; $display("FAIL wr_strobes got %0d %h %b want 2 202 0", n_strobe, log_addr[1], log_rw[0]); end
    @(negedge clk);
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL wr_one_shot got %b want 0", resp_valid); end
  endtask

  task automatic test_byte_half();
    int lat; logic [31:0] rd; logic er;
    rd_vals[0] = 16'h5A77; rd_vals[1] = 16'h5A77;
    do_req(1'b0, 2'd0, 32'h301, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h5A || lat !== 6 || n_strobe !== 1) begin n_err++; $display("FAIL br_odd got %h lat %0d n %0d want 5a 6 1", rd, lat, n_strobe); end
    do_req(1'b0, 2'd0, 32'h300, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h77 || n_strobe !== 1) begin n_err++; $display("FAIL br_even got %h n %0d want 77 1", rd, n_strobe); end
    do_req(1'b1, 2'd0, 32'h401, 32'hC3, lat, rd, er);
    n_vec++; if (log_dtw[0] !== 16'hC3C3 || log_addr[0] !== 32'h401 || rd !== 32'h0) begin n_err++; $display("FAIL bw got %h @%h rd %h want c3c3 @401 0", log_dtw[0], log_addr[0], rd); end
    rd_vals[0] = 16'h8001;
    do_req(1'b0, 2'd1, 32'h502, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h8001 || lat !== 6 || er !== 1'b0) begin n_err++; $display("FAIL hr got %h lat %0d err %b want 8001 6 0", rd, lat, er); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 2'd2, 32'h102, 32'h0, lat, rd, er);
    n_vec++; if (er !== 1'b1 || lat !== 1 || n_strobe !== 0) begin n_err++; $display("FAIL mis_word got err %b lat %0d n %0d want 1 1 0", er, lat, n_strobe); end
    do_req(1'b1, 2'd3, 32'h0, 32'h0, lat, rd, er);
    n_vec++; if (er !== 1'b1 || lat !== 1 || n_strobe !== 0) begin n_err++; $display("FAIL size3 got err %b lat %0d n %0d want 1 1 0", er, lat, n_strobe); end
    do_req(1'b0, 2'd1, 32'h503, 32'h0, lat, rd, er);
    n_vec++; if (er !== 1'b1 || rd !== 32'h0 || n_strobe !== 0) begin n_err++; $display("FAIL mis_half got err %b rd %h n %0d want 1 0 0", er, rd, n_strobe); end
  endtask

  task automatic test_reset_mid();
    int w; int seen;
    rd_vals[0] = 16'h1111; rd_vals[1] = 16'h2222;
    @(negedge clk);
    n_strobe = 0; n_rd = 0;
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'd2; req_addr = 32'h700; req_wdata = 32'h55AA33CC;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (n_strobe < 2 && w < 40) begin @(negedge clk); w++; end
    n_vec++; if (n_strobe !== 2) begin n_err++; $display("FAIL rm_reach_hi got %0d strobes want 2", n_strobe); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({req_ready, resp_valid, sram_valid, sram_rw} !== 4'b1000) begin n_err++; $display("FAIL rm_flags got %b want 1000", {req_ready, resp_valid, sram_valid, sram_rw}); end
    n_vec++; if ({sram_addr, sram_dtw} !== 48'b0) begin n_err++; $display("FAIL rm_data got %h %h want 0 0", sram_addr, sram_dtw); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (resp_valid || sram_valid) seen++; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rm_quiet got %0d active cycles want 0", seen); end
  endtask

`ifdef SRAM_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [31:0] rd; logic er;
    seq_mute = 1;
    do_req(1'b0, 2'd2, 32'h600, 32'h0, lat, rd, er);
    seq_mute = 0;
    n_vec++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 66 || n_strobe !== 1) begin n_err++; $display("FAIL timeout got err %b rd %h lat %0d n %0d want 1 0 66 1", er, rd, lat, n_strobe); end
  endtask
`endif

  initial begin
    test_reset();
    test_word_write();
    test_word_read();
    test_byte_half();
    test_errors();
`ifdef SRAM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
